pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MD_TIMEOUT, default 40, meaning the max multdiv wait cycles before abort.
REQ-002 SHALL have port clock  in  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  in  1  synchronous, active-low reset; sampled on the rising clock edge.
REQ-004 SHALL have ports dOpcode, dRs, dRt  in  5 each  decode-stage opcode and source registers; dUsesRt  in  1  decode instruction reads dRt.
REQ-005 SHALL have ports xOpcode, xRd  in  5 each  execute-stage opcode and destination.
REQ-006 SHALL have ports xTaken  in  1  X-stage branch/jump redirect; xMultDiv  in  1  X-stage holds mul/div; mdReady  in  1  multdiv result valid.
REQ-007 SHALL have ports pcEnable, fdEnable, dxEnable, xmEnable  out  1 each  latch write enables; fdFlush, dxFlush  out  1 each  bubble insert.
REQ-008 SHALL have ports mdStart  out  1  one-cycle multdiv start; mdTimeout  out  1  sticky abort flag; state  out  2  FSM state; stallCycles  out  16  stall counter.

Function
REQ-009 SHALL implement FSM states RUN=00, MD_WAIT=01, DRAIN=10; encoding 11 SHALL be treated as RUN.
REQ-010 SHALL, in RUN with no event, drive all enables 1, flushes 0, mdStart 0.
REQ-011 SHALL apply event priority in RUN: xMultDiv > xTaken > load-use.
REQ-012 SHALL detect load-use as xOpcode==01000, xRd!=0, and (dRs==xRd or (dUsesRt and dRt==xRd)).
REQ-013 SHALL, on load-use in RUN: pcEnable=0, fdEnable=0, dxEnable=1, dxFlush=1, xmEnable=1; one stall cycle only; state stays RUN.
REQ-014 SHALL, on xTaken in RUN: all enables 1, fdFlush=1, dxFlush=1, same cycle (combinational); suppresses load-use stall.
REQ-015 SHALL, on xMultDiv in RUN: mdStart=1 for exactly that cycle, all enables 0, next state MD_WAIT, wait counter cleared to 0.
REQ-016 SHALL, in MD_WAIT: all enables 0, mdStart 0, wait counter +1 per cycle.
REQ-017 SHALL, in MD_WAIT with mdReady=1: all enables 1 that cycle, next state DRAIN.
REQ-018 SHALL, in MD_WAIT when wait counter reaches MD_TIMEOUT without mdReady: set mdTimeout=1 (sticky until reset), all enables 1 and dxFlush=1 that cycle, next state DRAIN.
REQ-019 SHALL, in DRAIN: behave as RUN for outputs except mdStart forced 0 and xMultDiv ignored; next state RUN (one cycle), preventing restart on the same instruction.
REQ-020 SHALL ignore mdReady outside MD_WAIT.
REQ-021 SHALL increment stallCycles each cycle pcEnable==0 (reset excluded), saturating at 0xFFFF.
REQ-022 SHALL keep wait counter width ceil(log2(MD_TIMEOUT+1)) bits, never wrapping.

Reset
REQ-023 SHALL, when reset==0 at a rising edge, set state=RUN, wait counter=0, stallCycles=0, mdTimeout=0.
REQ-024 SHALL, while reset==0, drive all enables 0, fdFlush=1, dxFlush=1, mdStart=0.
REQ-025 SHALL abandon MD_WAIT/DRAIN immediately on reset; no mdStart reissued after reset deasserts.

Verification
REQ-026 SHALL cover: xOpcode=01000, xRd=5, dRs=5 in RUN -> one cycle pcEnable=fdEnable=0, dxFlush=1, stallCycles=1.
REQ-027 SHALL cover: xOpcode=01000, xRd=0, dRs=0 -> no stall, all enables 1.
REQ-028 SHALL cover: xTaken=1 with load-use hazard present -> fdFlush=dxFlush=1, pcEnable=1, stallCycles unchanged.
REQ-029 SHALL cover: xMultDiv=1, mdReady after 10 cycles -> mdStart high 1 cycle, enables 0 for 10 cycles, enables 1 on ready cycle, state MD_WAIT->DRAIN->RUN, stallCycles=11.
REQ-030 SHALL cover: xMultDiv=1, mdReady never -> mdTimeout=1 after MD_TIMEOUT wait cycles, dxFlush=1 that cycle, returns to RUN via DRAIN.
REQ-031 SHALL cover: reset=0 asserted mid-MD_WAIT -> next cycle state=00, stallCycles=0, mdTimeout=0, mdStart=0 after release.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush controller for a 5-stage pipeline with load-use,
// branch redirect and multi-cycle multdiv handling (wait, timeout, drain).
module pipeline_ctrl #(
    parameter int MD_TIMEOUT = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  dOpcode,
    input  logic [4:0]  dRs,
    input  logic [4:0]  dRt,
    input  logic        dUsesRt,
    input  logic [4:0]  xOpcode,
    input  logic [4:0]  xRd,
    input  logic        xTaken,
    input  logic        xMultDiv,
    input  logic        mdReady,
    output logic        pcEnable,
    output logic        fdEnable,
    output logic        dxEnable,
    output logic        xmEnable,
    output logic        fdFlush,
    output logic        dxFlush,
    output logic        mdStart,
    output logic        mdTimeout,
    output logic [1:0]  state,
    output logic [15:0] stallCycles
);
    localparam logic [1:0] RUN     = 2'b00;
    localparam logic [1:0] MD_WAIT = 2'b01;
    localparam logic [1:0] DRAIN   = 2'b10;
    localparam int CW = $clog2(MD_TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_VAL = CW'(MD_TIMEOUT);

    logic [CW-1:0] waitCnt;
    logic [1:0] nextState;
    logic inWait, inDrain, inRun, loadUse, mdBegin, waitHold, mdAbort, redirect, bubble, freeze;
    logic unusedOpcode;

    assign unusedOpcode = ^dOpcode;

    always_comb begin
        inWait    = state == MD_WAIT;
        inDrain   = state == DRAIN;
        inRun     = !inWait && !inDrain;
        loadUse   = xOpcode == 5'b01000 && xRd != 5'd0 && (dRs == xRd || (dUsesRt && dRt == xRd));
        mdBegin   = inRun && xMultDiv;
        waitHold  = inWait && !mdReady && waitCnt != TIMEOUT_VAL;
        mdAbort   = inWait && !mdReady && waitCnt == TIMEOUT_VAL;
        // Redirect and load-use only act outside MD_WAIT and lose to a multdiv start.
        redirect  = !inWait && !mdBegin && xTaken;
        bubble    = !inWait && !mdBegin && !xTaken && loadUse;
        freeze    = mdBegin || waitHold;
        pcEnable  = reset && !freeze && !bubble;
        fdEnable  = reset && !freeze && !bubble;
        dxEnable  = reset && !freeze;
        xmEnable  = reset && !freeze;
        fdFlush   = !reset || redirect;
        dxFlush   = !reset || redirect || bubble || mdAbort;
        mdStart   = reset && mdBegin;
        nextState = inWait ? ((mdReady || mdAbort) ? DRAIN : MD_WAIT) : (mdBegin ? MD_WAIT : RUN);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= RUN;
            waitCnt     <= '0;
            stallCycles <= 16'd0;
            mdTimeout   <= 1'b0;
        end else begin
            state     <= nextState;
            waitCnt   <= mdBegin ? '0 : (waitHold ? waitCnt + 1'b1 : waitCnt);
            mdTimeout <= mdTimeout || mdAbort;
            if (!pcEnable && stallCycles != 16'hFFFF)
                stallCycles <= stallCycles + 16'd1;
        end
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed-vector bench for pipeline_ctrl, one task per scenario.
module tb_pipeline_ctrl;
    logic clock = 1'b0;
    logic reset;
    logic [4:0] dOpcode, dRs, dRt, xOpcode, xRd;
    logic dUsesRt, xTaken, xMultDiv, mdReady;
    logic pcEnable, fdEnable, dxEnable, xmEnable, fdFlush, dxFlush, mdStart, mdTimeout;
    logic [1:0] state;
    logic [15:0] stallCycles;
    logic [6:0] ctl;
    logic [15:0] expStall;
    int checks = 0;
    int errors = 0;

    pipeline_ctrl dut (
        .clock(clock), .reset(reset), .dOpcode(dOpcode), .dRs(dRs), .dRt(dRt), .dUsesRt(dUsesRt),
        .xOpcode(xOpcode), .xRd(xRd), .xTaken(xTaken), .xMultDiv(xMultDiv), .mdReady(mdReady),
        .pcEnable(pcEnable), .fdEnable(fdEnable), .dxEnable(dxEnable), .xmEnable(xmEnable),
        .fdFlush(fdFlush), .dxFlush(dxFlush), .mdStart(mdStart), .mdTimeout(mdTimeout),
        .state(state), .stallCycles(stallCycles)
    );

    // ctl = {pcEnable, fdEnable, dxEnable, xmEnable, fdFlush, dxFlush, mdStart}
    assign ctl = {pcEnable, fdEnable, dxEnable, xmEnable, fdFlush, dxFlush, mdStart};

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle;
        dOpcode = 5'd0; dRs = 5'd0; dRt = 5'd0; dUsesRt = 1'b0;
        xOpcode = 5'd0; xRd = 5'd0; xTaken = 1'b0; xMultDiv = 1'b0; mdReady = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        idle();
        #1;
        checks++; if (ctl !== 7'b0000110) begin errors++; $display("FAIL reset_ctl: got %b want %b", ctl, 7'b0000110); end
        tick();
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b want %b", state, 2'b00); end
        checks++; if (stallCycles !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", stallCycles); end
        checks++; if (mdTimeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", mdTimeout); end
        reset = 1'b1;
        #1;
        checks++; if (ctl !== 7'b1111000) begin errors++; $display("FAIL run_idle_ctl: got %b want %b", ctl, 7'b1111000); end
        tick();
        expStall = 16'd0;
    endtask

    task automatic test_load_use;
        xOpcode = 5'b01000; xRd = 5'd5; dRs = 5'd5;
        #1;
        checks++; if (ctl !== 7'b0011010) begin errors++; $display("FAIL loaduse_rs_ctl: got %b want %b", ctl, 7'b0011010); end
        tick();
        idle();
        expStall = expStall + 16'd1;
        #1;
        checks++; if (stallCycles !== expStall) begin errors++; $display("FAIL loaduse_rs_stall: got %0d want %0d", stallCycles, expStall); end
        checks++; if (ctl !== 7'b1111000) begin errors++; $display("FAIL loaduse_one_cycle: got %b want %b", ctl, 7'b1111000); end
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL loaduse_state: got %b want 00", state); end
        xOpcode = 5'b01000; xRd = 5'd7; dRs = 5'd1; dRt = 5'd7; dUsesRt = 1'b1;
        #1;
        checks++; if (ctl !== 7'b0011010) begin errors++; $display("FAIL loaduse_rt_ctl: got %b want %b", ctl, 7'b0011010); end
        dUsesRt = 1'b0;
        #1;
        checks++; if (ctl !== 7'b1111000) begin errors++; $display("FAIL loaduse_rt_unused: got %b want %b", ctl, 7'b1111000); end
        xOpcode = 5'b01001; dRs = 5'd7;
        #1;
        checks++; if (ctl !== 7'b1111000) begin errors++; $display("FAIL non_load_opcode: got %b want %b", ctl, 7'b1111000); end
        tick();
        idle();
    endtask

    task automatic test_r0_and_ready;
        xOpcode = 5'b01000; xRd = 5'd0; dRs = 5'd0; mdReady = 1'b1;
        #1;
        checks++; if (ctl !== 7'b1111000) begin errors++; $display("FAIL r0_no_stall: got %b want %b", ctl, 7'b1111000); end
        tick();
        idle();
        #1;
        checks++; if (stallCycles !== expStall) begin errors++; $display("FAIL r0_stall_count: got %0d want %0d", stallCycles, expStall); end
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL ready_ignored_state: got %b want 00", state); end
    endtask

    task automatic test_taken;
        xOpcode = 5'b01000; xRd = 5'd5; dRs = 5'd5; xTaken = 1'b1;
        #1;
        checks++; if (ctl !== 7'b1111110) begin errors++; $display("FAIL taken_ctl: got %b want %b", ctl, 7'b1111110); end
        tick();
        idle();
        #1;
        checks++; if (stallCycles !== expStall) begin errors++; $display("FAIL taken_stall: got %0d want %0d", stallCycles, expStall); end
    endtask

    task automatic test_multdiv_ready;
        xMultDiv = 1'b1; xTaken = 1'b1;
        #1;
        checks++; if (ctl !== 7'b0000001) begin errors++; $display("FAIL md_start_ctl: got %b want %b", ctl, 7'b0000001); end
        tick();
        idle();
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++; if (ctl !== 7'b0000000 || state !== 2'b01) begin errors++; $display("FAIL md_wait_%0d: got ctl %b state %b want 0000000 01", i, ctl, state); end
            tick();
        end
        mdReady = 1'b1;
        #1;
        checks++; if (ctl !== 7'b1111000) begin errors++; $display("FAIL md_ready_ctl: got %b want %b", ctl, 7'b1111000); end
        tick();
        mdReady = 1'b0; xMultDiv = 1'b1;
        #1;
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL md_drain_state: got %b want 10", state); end
        checks++; if (ctl !== 7'b1111000) begin errors++; $display("FAIL md_drain_ctl: got %b want %b", ctl, 7'b1111000); end
        tick();
        idle();
        expStall = expStall + 16'd11;
        #1;
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL md_back_run: got %b want 00", state); end
        checks++; if (stallCycles !== expStall) begin errors++; $display("FAIL md_stall: got %0d want %0d", stallCycles, expStall); end
        checks++; if (mdTimeout !== 1'b0) begin errors++; $display("FAIL md_no_timeout: got %b want 0", mdTimeout); end
    endtask

    task automatic test_multdiv_timeout;
        xMultDiv = 1'b1;
        #1;
        tick();
        idle();
        for (int i = 0; i < 40; i++) begin
            #1;
            checks++; if (ctl !== 7'b0000000 || mdTimeout !== 1'b0) begin errors++; $display("FAIL to_wait_%0d: got ctl %b to %b want 0000000 0", i, ctl, mdTimeout); end
            tick();
        end
        #1;
        checks++; if (ctl !== 7'b1111010 || state !== 2'b01) begin errors++; $display("FAIL to_abort: got ctl %b state %b want 1111010 01", ctl, state); end
        tick();
        checks++; if (state !== 2'b10 || mdTimeout !== 1'b1) begin errors++; $display("FAIL to_drain: got state %b to %b want 10 1", state, mdTimeout); end
        tick();
        expStall = expStall + 16'd41;
        checks++; if (state !== 2'b00 || mdTimeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got state %b to %b want 00 1", state, mdTimeout); end
        checks++; if (stallCycles !== expStall) begin errors++; $display("FAIL to_stall: got %0d want %0d", stallCycles, expStall); end
    endtask

    task automatic test_reset_mid_wait;
        xMultDiv = 1'b1;
        #1;
        tick();
        idle();
        tick();
        tick();
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL rst_pre_wait: got %b want 01", state); end
        reset = 1'b0;
        #1;
        checks++; if (ctl !== 7'b0000110) begin errors++; $display("FAIL rst_mid_ctl: got %b want %b", ctl, 7'b0000110); end
        tick();
        checks++; if (state !== 2'b00 || stallCycles !== 16'd0 || mdTimeout !== 1'b0) begin errors++; $display("FAIL rst_mid_regs: got state %b stall %0d to %b want 00 0 0", state, stallCycles, mdTimeout); end
        reset = 1'b1;
        #1;
        checks++; if (ctl !== 7'b1111000) begin errors++; $display("FAIL rst_release_ctl: got %b want %b", ctl, 7'b1111000); end
        tick();
        checks++; if (mdStart !== 1'b0 || state !== 2'b00) begin errors++; $display("FAIL rst_no_restart: got md %b state %b want 0 00", mdStart, state); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_r0_and_ready();
        test_taken();
        test_multdiv_ready();
        test_multdiv_timeout();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
